// File: rtl/swap_sequencer_if.sv
// Handshake bundle between swap_sequencer, the render engines and the swap logic.
// master: sequencer side; slave: engines/display side.
interface swap_sequencer_if #(
    parameter int NUM_STAGES = 2
) ();
    logic [NUM_STAGES-1:0] stage_start;
    logic [NUM_STAGES-1:0] stage_start_ack;
    logic [NUM_STAGES-1:0] stage_done;
    logic [NUM_STAGES-1:0] stage_done_ack;
    logic                  swap;
    logic                  swap_ack;

    modport master (
        output stage_start,
        output stage_done_ack,
        output swap,
        input  stage_start_ack,
        input  stage_done,
        input  swap_ack
    );

    modport slave (
        input  stage_start,
        input  stage_done_ack,
        input  swap,
        output stage_start_ack,
        output stage_done,
        output swap_ack
    );
endinterface

// File: rtl/swap_sequencer.sv
// Frame sequencer: runs masked render stages in index order, then requests a swap.
// Ports: clock/reset, enable, stage_mask, timeout_limit, err_clear, bus (master), status.
module swap_sequencer #(
    parameter int NUM_STAGES  = 2,
    parameter int SYNC_STAGES = 2,
    parameter int TIMEOUT_W   = 16,
    parameter int FRAME_CNT_W = 16,
    localparam int CUR_W = (NUM_STAGES > 1) ? $clog2(NUM_STAGES) : 1
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   enable,
    input  logic [NUM_STAGES-1:0]  stage_mask,
    input  logic [TIMEOUT_W-1:0]   timeout_limit,
    input  logic                   err_clear,
    swap_sequencer_if.master       bus,
    output logic                   busy,
    output logic [CUR_W-1:0]       cur_stage,
    output logic [FRAME_CNT_W-1:0] frame_count,
    output logic                   timeout_err,
    output logic [CUR_W:0]         timeout_stage
);

    typedef enum logic [1:0] {IDLE, START, WAIT_DONE, SWAP} state_e;

    state_e                 state_q, state_d;
    logic [NUM_STAGES-1:0]  mask_q, mask_d;
    logic [CUR_W-1:0]       cur_q, cur_d;
    logic [TIMEOUT_W-1:0]   cnt_q, cnt_d;
    logic [FRAME_CNT_W-1:0] frame_q, frame_d;
    logic                   err_q, err_d;
    logic [CUR_W:0]         err_stage_q, err_stage_d;
    logic [NUM_STAGES-1:0]  start_q, start_d;
    logic                   swap_q, swap_d;
    logic [NUM_STAGES-1:0]  sync_q [SYNC_STAGES];
    logic [NUM_STAGES-1:0]  sync_d [SYNC_STAGES];
    logic [NUM_STAGES-1:0]  ack_r_q, ack_r_d;

    logic [NUM_STAGES-1:0]  done_ack;
    logic [NUM_STAGES-1:0]  done_edge;
    logic [CUR_W:0]         first;
    logic [CUR_W:0]         nxt;
    logic                   hit;
    logic                   fire;

    // {found, index} of the lowest set bit of m at or above index from.
    function automatic logic [CUR_W:0] first_set(
        input logic [NUM_STAGES-1:0] m,
        input int                    from
    );
        logic [CUR_W:0] res;
        res = '0;
        for (int i = NUM_STAGES - 1; i >= 0; i--) begin
            if (i >= from && m[i]) begin
                res = {1'b1, CUR_W'(i)};
            end
        end
        return res;
    endfunction

    assign done_ack  = sync_q[SYNC_STAGES-1];
    assign done_edge = done_ack & ~ack_r_q;

    always_comb begin
        state_d     = state_q;
        mask_d      = mask_q;
        cur_d       = cur_q;
        cnt_d       = cnt_q;
        frame_d     = frame_q;
        err_d       = err_q;
        err_stage_d = err_stage_q;
        start_d     = '0;
        swap_d      = 1'b0;
        fire        = 1'b0;

        sync_d[0] = bus.stage_done;
        for (int k = 1; k < SYNC_STAGES; k++) begin
            sync_d[k] = sync_q[k-1];
        end
        ack_r_d = done_ack;

        first = first_set(stage_mask, 0);
        nxt   = first_set(mask_q, int'(cur_q) + 1);
        hit   = (timeout_limit != '0) &&
                (cnt_q == timeout_limit - TIMEOUT_W'(1));

        if (err_clear) begin
            err_d       = 1'b0;
            err_stage_d = '0;
        end

        // Requests are registered from the current state, so they appear
        // one cycle after the state is entered and drop with the ack.
        unique case (state_q)
            IDLE: begin
                if (enable) begin
                    mask_d  = stage_mask;
                    cnt_d   = '0;
                    cur_d   = first[CUR_W-1:0];
                    state_d = first[CUR_W] ? START : SWAP;
                end
            end
            START: begin
                cnt_d = cnt_q + TIMEOUT_W'(1);
                if (bus.stage_start_ack[cur_q]) begin
                    cnt_d   = '0;
                    state_d = WAIT_DONE;
                end else if (hit) begin
                    fire = 1'b1;
                end else begin
                    start_d[cur_q] = 1'b1;
                end
            end
            WAIT_DONE: begin
                cnt_d = cnt_q + TIMEOUT_W'(1);
                if (done_edge[cur_q]) begin
                    cnt_d = '0;
                    if (nxt[CUR_W]) begin
                        cur_d   = nxt[CUR_W-1:0];
                        state_d = START;
                    end else begin
                        state_d = SWAP;
                    end
                end else if (hit) begin
                    fire = 1'b1;
                end
            end
            SWAP: begin
                cnt_d = cnt_q + TIMEOUT_W'(1);
                if (bus.swap_ack) begin
                    frame_d = frame_q + FRAME_CNT_W'(1);
                    cnt_d   = '0;
                    if (enable) begin
                        mask_d  = stage_mask;
                        cur_d   = first[CUR_W-1:0];
                        state_d = first[CUR_W] ? START : SWAP;
                    end else begin
                        cur_d   = '0;
                        state_d = IDLE;
                    end
                end else if (hit) begin
                    fire = 1'b1;
                end else begin
                    swap_d = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        // First timeout is kept unless cleared in this same cycle.
        if (fire) begin
            state_d = IDLE;
            cur_d   = '0;
            cnt_d   = '0;
            err_d   = 1'b1;
            if (!err_q || err_clear) begin
                err_stage_d = (state_q == SWAP) ?
                    {1'b1, {CUR_W{1'b0}}} : {1'b0, cur_q};
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= IDLE;
            mask_q      <= '0;
            cur_q       <= '0;
            cnt_q       <= '0;
            frame_q     <= '0;
            err_q       <= 1'b0;
            err_stage_q <= '0;
            start_q     <= '0;
            swap_q      <= 1'b0;
            ack_r_q     <= '0;
            for (int k = 0; k < SYNC_STAGES; k++) begin
                sync_q[k] <= '0;
            end
        end else begin
            state_q     <= state_d;
            mask_q      <= mask_d;
            cur_q       <= cur_d;
            cnt_q       <= cnt_d;
            frame_q     <= frame_d;
            err_q       <= err_d;
            err_stage_q <= err_stage_d;
            start_q     <= start_d;
            swap_q      <= swap_d;
            ack_r_q     <= ack_r_d;
            for (int k = 0; k < SYNC_STAGES; k++) begin
                sync_q[k] <= sync_d[k];
            end
        end
    end

    assign bus.stage_start    = start_q;
    assign bus.stage_done_ack = done_ack;
    assign bus.swap           = swap_q;
    assign busy               = (state_q != IDLE);
    assign cur_stage          = cur_q;
    assign frame_count        = frame_q;
    assign timeout_err        = err_q;
    assign timeout_stage      = err_stage_q;

endmodule

// File: tb/tb_swap_sequencer.sv
// Directed bench for swap_sequencer: frame table plus timeout/reset/wrap sequences.
// Engines and swap logic are modelled by a negedge responder process.
module tb_swap_sequencer;

    logic        clock = 1'b0;
    logic        reset;
    logic        enable;
    logic [1:0]  stage_mask;
    logic [15:0] timeout_limit;
    logic        err_clear;
    logic        busy;
    logic [0:0]  cur_stage;
    logic [3:0]  frame_count;
    logic        timeout_err;
    logic [1:0]  timeout_stage;

    always #5 clock = ~clock;

    swap_sequencer_if #(.NUM_STAGES(2)) bus ();

    swap_sequencer #(
        .NUM_STAGES(2),
        .SYNC_STAGES(2),
        .TIMEOUT_W(16),
        .FRAME_CNT_W(4)
    ) dut (
        .clock(clock),
        .reset(reset),
        .enable(enable),
        .stage_mask(stage_mask),
        .timeout_limit(timeout_limit),
        .err_clear(err_clear),
        .bus(bus),
        .busy(busy),
        .cur_stage(cur_stage),
        .frame_count(frame_count),
        .timeout_err(timeout_err),
        .timeout_stage(timeout_stage)
    );

    // Responder / monitor state (written only by the negedge process).
    logic [1:0] resp_done = '0;
    logic [1:0] resp_ack = '0;
    logic       resp_swap_ack = 1'b0;
    int         cnt [2] = '{0, 0};
    int         hold [2] = '{0, 0};
    int         cyc = 0;
    int         clr_seen = 0;
    logic [1:0] started = '0;
    logic [1:0] cur_seen = '0;
    int         t_busy = -1, t_swap = -1, t_done0 = -1;
    int         t_start1 = -1, t_s1_fall = -1, t_fall = -1;
    int         swaps = 0, falls = 0;
    logic       busy_p = 1'b0, swap_p = 1'b0;
    logic [1:0] start_p = '0;

    // Controls (written only by the initial block).
    logic [1:0] extra_done = '0;
    logic [1:0] blk_done = '0;
    logic       blk_swap = 1'b0;
    int         clr_id = 0;

    assign bus.stage_done      = resp_done | extra_done;
    assign bus.stage_start_ack = resp_ack;
    assign bus.swap_ack        = resp_swap_ack;

    always @(negedge clock) begin
        cyc = cyc + 1;
        if (clr_seen != clr_id) begin
            clr_seen  = clr_id;
            started   = '0;
            cur_seen  = '0;
            t_busy    = -1;
            t_swap    = -1;
            t_done0   = -1;
            t_start1  = -1;
            t_s1_fall = -1;
            t_fall    = -1;
            swaps     = 0;
            falls     = 0;
        end
        if (busy && !busy_p) t_busy = cyc;
        if (!busy && busy_p) begin
            t_fall = cyc;
            falls  = falls + 1;
        end
        if (bus.swap && !swap_p) begin
            if (t_swap < 0) t_swap = cyc;
            swaps = swaps + 1;
        end
        for (int i = 0; i < 2; i++) begin
            if (bus.stage_start[i] && !start_p[i]) started[i] = 1'b1;
        end
        if (|bus.stage_start) cur_seen[cur_stage] = 1'b1;
        if (bus.stage_start[1] && !start_p[1]) t_start1 = cyc;
        if (!bus.stage_start[1] && start_p[1]) t_s1_fall = cyc;
        busy_p  = busy;
        swap_p  = bus.swap;
        start_p = bus.stage_start;

        // Ack while requested; done rises 5 cycles after ack, high 4 cycles.
        for (int i = 0; i < 2; i++) begin
            resp_ack[i] = bus.stage_start[i];
            if (bus.stage_start[i]) begin
                if (!blk_done[i]) cnt[i] = 5;
            end else if (cnt[i] > 0) begin
                cnt[i] = cnt[i] - 1;
                if (cnt[i] == 0) begin
                    resp_done[i] = 1'b1;
                    hold[i] = 4;
                    if (i == 0) t_done0 = cyc;
                end
            end else if (hold[i] > 0) begin
                hold[i] = hold[i] - 1;
                if (hold[i] == 0) resp_done[i] = 1'b0;
            end
        end
        resp_swap_ack = bus.swap & ~blk_swap;
    end

    int         checks = 0;
    int         errors = 0;
    logic [3:0] exp_fc = '0;

    task automatic chk(input string name, input longint act, input longint req);
        checks = checks + 1;
        if (act != req) begin
            errors = errors + 1;
            $display("FAIL %s actual=%0d required=%0d", name, act, req);
        end
    endtask

    task automatic step();
        @(negedge clock);
        #1;
    endtask

    task automatic wait_idle(input string name);
        for (int k = 0; k < 300 && busy; k++) step();
        chk(name, busy, 0);
    endtask

    // One frame: enable until the frame starts, then let it run out.
    task automatic run_frame(input logic [1:0] m, input bit inject);
        stage_mask = m;
        enable = 1'b1;
        clr_id = clr_id + 1;
        for (int k = 0; k < 20 && !busy; k++) step();
        chk("frame_started", busy, 1);
        enable = 1'b0;
        for (int k = 0; k < 300 && busy; k++) begin
            step();
            extra_done[1] = inject && (k >= 1) && (k < 5);
        end
        extra_done = '0;
        chk("frame_ended", busy, 0);
    endtask

    typedef struct {
        logic [1:0] mask;
        bit         inject;
        logic [1:0] exp_started;
        logic [1:0] exp_cur;
        int         exp_lat;
        int         exp_d2s;
    } vec_t;

    vec_t vecs [5];

    initial begin
        vecs[0] = '{2'b11, 1'b0, 2'b11, 2'b11, 19, 4};
        vecs[1] = '{2'b10, 1'b0, 2'b10, 2'b10, 10, -1};
        vecs[2] = '{2'b01, 1'b0, 2'b01, 2'b01, 10, -1};
        vecs[3] = '{2'b00, 1'b0, 2'b00, 2'b00, 1, -1};
        vecs[4] = '{2'b11, 1'b1, 2'b11, 2'b11, 19, 4};

        reset = 1'b1;
        enable = 1'b0;
        stage_mask = '0;
        timeout_limit = '0;
        err_clear = 1'b0;
        repeat (3) step();

        chk("rst_busy", busy, 0);
        chk("rst_swap", bus.swap, 0);
        chk("rst_start", bus.stage_start, 0);
        chk("rst_done_ack", bus.stage_done_ack, 0);
        chk("rst_frame", frame_count, 0);
        chk("rst_cur", cur_stage, 0);
        chk("rst_err", timeout_err, 0);
        chk("rst_tstage", timeout_stage, 0);
        reset = 1'b0;
        step();

        for (int v = 0; v < 5; v++) begin
            run_frame(vecs[v].mask, vecs[v].inject);
            exp_fc = exp_fc + 4'd1;
            chk("tbl_started", started, vecs[v].exp_started);
            chk("tbl_cur_seen", cur_seen, vecs[v].exp_cur);
            chk("tbl_swap_lat", t_swap - t_busy, vecs[v].exp_lat);
            chk("tbl_done_to_start",
                (t_done0 >= 0 && t_start1 >= 0) ? t_start1 - t_done0 : -1,
                vecs[v].exp_d2s);
            chk("tbl_swaps", swaps, 1);
            chk("tbl_frame", frame_count, exp_fc);
            chk("tbl_err", timeout_err, 0);
        end

        // Done edge lands exactly on the limit cycle: event wins.
        timeout_limit = 16'd7;
        run_frame(2'b11, 1'b0);
        exp_fc = exp_fc + 4'd1;
        chk("lim7_err", timeout_err, 0);
        chk("lim7_frame", frame_count, exp_fc);
        chk("lim7_lat", t_swap - t_busy, 19);
        timeout_limit = '0;

        // Back-to-back frames with no idle cycle.
        stage_mask = 2'b11;
        enable = 1'b1;
        clr_id = clr_id + 1;
        for (int k = 0; k < 300 && swaps < 2; k++) step();
        chk("b2b_swaps", swaps, 2);
        chk("b2b_no_idle", falls, 0);
        chk("b2b_busy", busy, 1);
        enable = 1'b0;
        wait_idle("b2b_idle");
        exp_fc = exp_fc + 4'd2;
        chk("b2b_frame", frame_count, exp_fc);
        chk("b2b_falls", falls, 1);

        // Stage 1 never finishes.
        timeout_limit = 16'd8;
        blk_done = 2'b10;
        run_frame(2'b11, 1'b0);
        chk("to1_err", timeout_err, 1);
        chk("to1_tstage", timeout_stage, 2'b01);
        chk("to1_wait_cycles", t_fall - t_s1_fall, 8);
        chk("to1_start", bus.stage_start, 0);
        chk("to1_frame", frame_count, exp_fc);
        chk("to1_swaps", swaps, 0);
        blk_done = '0;

        // Swap timeout while the first error is held.
        blk_swap = 1'b1;
        run_frame(2'b00, 1'b0);
        chk("tos_keep_tstage", timeout_stage, 2'b01);
        chk("tos_err", timeout_err, 1);
        chk("tos_cycles", t_fall - t_busy, 8);
        chk("tos_swap", bus.swap, 0);
        chk("tos_frame", frame_count, exp_fc);

        err_clear = 1'b1;
        step();
        err_clear = 1'b0;
        chk("clr_err", timeout_err, 0);
        chk("clr_tstage", timeout_stage, 0);

        run_frame(2'b00, 1'b0);
        chk("tos2_tstage", timeout_stage, 2'b10);
        chk("tos2_err", timeout_err, 1);
        blk_swap = 1'b0;

        err_clear = 1'b1;
        step();
        err_clear = 1'b0;
        chk("clr2_err", timeout_err, 0);

        // Limit one short: stage 0 times out just before its edge.
        timeout_limit = 16'd6;
        run_frame(2'b11, 1'b0);
        chk("lim6_err", timeout_err, 1);
        chk("lim6_tstage", timeout_stage, 2'b00);
        chk("lim6_started", started, 2'b01);
        chk("lim6_cycles", t_fall - t_busy, 8);
        chk("lim6_frame", frame_count, exp_fc);

        err_clear = 1'b1;
        step();
        err_clear = 1'b0;
        timeout_limit = 16'd8;
        run_frame(2'b11, 1'b0);
        exp_fc = exp_fc + 4'd1;
        chk("recover_frame", frame_count, exp_fc);
        chk("recover_err", timeout_err, 0);
        timeout_limit = '0;

        // Frame counter wrap at 4 bits.
        reset = 1'b1;
        step();
        reset = 1'b0;
        exp_fc = '0;
        chk("wrap_rst_frame", frame_count, 0);
        stage_mask = 2'b00;
        enable = 1'b1;
        clr_id = clr_id + 1;
        for (int k = 0; k < 300 && swaps < 15; k++) step();
        step();
        chk("wrap_frame15", frame_count, 15);
        enable = 1'b0;
        wait_idle("wrap_idle");
        chk("wrap_swaps", swaps, 16);
        chk("wrap_frame0", frame_count, 0);

        // Reset while a swap is pending.
        run_frame(2'b00, 1'b0);
        chk("pre_rst_frame", frame_count, 1);
        blk_swap = 1'b1;
        stage_mask = 2'b00;
        enable = 1'b1;
        for (int k = 0; k < 20 && !bus.swap; k++) step();
        chk("swap_pending", bus.swap, 1);
        reset = 1'b1;
        enable = 1'b0;
        step();
        chk("rs_swap", bus.swap, 0);
        chk("rs_busy", busy, 0);
        chk("rs_frame", frame_count, 0);
        chk("rs_start", bus.stage_start, 0);
        chk("rs_cur", cur_stage, 0);
        chk("rs_err", timeout_err, 0);
        chk("rs_tstage", timeout_stage, 0);
        chk("rs_done_ack", bus.stage_done_ack, 0);
        reset = 1'b0;
        blk_swap = 1'b0;
        step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/swap_sequencer.md
Name: swap_sequencer

Overview:
- Parametrised frame-swap sequencer that runs NUM_STAGES render stages (e.g. background, overlay, annotation) in fixed index order each frame, then requests a buffer swap.
- Each stage uses a start/start_ack request handshake and a done level that is synchronised and edge-detected.
- Adds over the two-stage controller: a per-frame stage mask, an enable/stop control, a per-wait timeout with sticky error, a frame counter and status outputs.
- Sits between the display/framebuffer swap logic and the render engines.

Parameters:
NUM_STAGES, 2, number of render stages (1..8)
SYNC_STAGES, 2, flops in each stage_done synchroniser (>=1)
TIMEOUT_W, 16, width of the timeout counter and timeout_limit
FRAME_CNT_W, 16, width of frame_count

Ports:
clock  in  1  system clock
reset  in  1  synchronous, active-high reset
enable  in  1  1 = run frames back to back; 0 = finish the current frame, then idle
stage_mask  in  NUM_STAGES  1 = stage runs this frame; sampled at frame start
timeout_limit  in  TIMEOUT_W  maximum cycles in any wait state; 0 = timeout disabled
err_clear  in  1  clears timeout_err
stage_start  out  NUM_STAGES  per-stage start request, held until acked
stage_start_ack  in  NUM_STAGES  per-stage start acknowledge
stage_done  in  NUM_STAGES  per-stage done level, asynchronous to clock
stage_done_ack  out  NUM_STAGES  synchronised copy of stage_done (acknowledge)
swap  out  1  buffer swap request, held until acked
swap_ack  in  1  swap acknowledge
busy  out  1  1 in any state other than IDLE
cur_stage  out  max(1,clog2(NUM_STAGES))  index of the active stage; 0 in IDLE
frame_count  out  FRAME_CNT_W  completed swaps, wraps modulo 2^FRAME_CNT_W
timeout_err  out  1  sticky timeout flag
timeout_stage  out  max(1,clog2(NUM_STAGES))+1  MSB=1 means swap timed out; else the stage index

Behaviour:
- Reset: every output is 0, including the synchronisers and edge registers; state = IDLE.
- Reset mid-frame aborts immediately: all requests drop the cycle after reset is sampled.
- Synchroniser: stage_done[i] passes through SYNC_STAGES flops to give stage_done_ack[i]. A further flop holds ack_r. Edge: done_edge[i] = stage_done_ack[i] & ~ack_r[i].
- Synchroniser latency: stage_done rise to stage_done_ack rise = SYNC_STAGES cycles; the edge is seen one cycle later.
- The synchronisers run in every state.

States:
- IDLE
  - If enable=1: latch stage_mask into mask_q, zero the timeout counter, and select the lowest set bit of the latched mask.
  - If that bit exists: go to START, with stage_start[i] asserted in the next cycle.
  - If the mask is 0: go straight to SWAP.
- START
  - stage_start[cur] = 1.
  - On stage_start_ack[cur]: drop the request on the next edge, go to WAIT_DONE, zero the timeout counter.
  - Acks on other stages are ignored.
- WAIT_DONE
  - Wait for done_edge[cur]. Edges on other stages, or seen in any other state, are discarded and not latched.
  - On the edge, move to the next higher set bit of mask_q and go to START. If there is none, go to SWAP.
  - The timeout counter is zeroed on every transition.
- SWAP
  - swap = 1.
  - On swap_ack: drop swap and increment frame_count (with wrap) on the same edge.
  - Then go to START/SWAP as in IDLE if enable=1 (a new frame with zero idle cycles, mask resampled), else go to IDLE.
- Timeout
  - Applies in START, WAIT_DONE and SWAP when timeout_limit != 0.
  - The counter increments each cycle in the state. When it equals timeout_limit-1 and the awaited event is absent that cycle:
    - set timeout_err;
    - load timeout_stage;
    - drop all requests;
    - go to IDLE; frame_count is unchanged.
  - An event arriving in the same cycle as the limit wins, and no timeout occurs.
- Errors
  - The first timeout is retained: timeout_stage is not overwritten while timeout_err=1.
  - err_clear zeroes both timeout_err and timeout_stage; a new timeout in the same cycle takes priority.
  - A timeout does not block further frames.
- Start semantics
  - At most one stage_start bit is high at any time. stage_start and swap are never high together.
  - enable falling mid-frame has no effect until that frame's swap completes.

Test Plan:
- NUM_STAGES=2, mask=2'b11, enable=1, acks after 1 cycle, stage_done[0] rises 5 cycles after its start ack -> stage_start[1] rises exactly SYNC_STAGES+2 cycles after done[0] rises; swap follows stage 1 done; frame_count=1; next frame starts with no idle cycle.
- mask=2'b10 -> stage 0 never started, cur_stage=1 during the frame; mask=2'b00 -> swap asserted 1 cycle after leaving IDLE, frame_count increments.
- timeout_limit=8, stage 1 never asserts done -> timeout_err=1 and timeout_stage=1 after 8 cycles in WAIT_DONE; stage_start=0, busy=0, frame_count unchanged; err_clear -> both 0.
- stage_done[1] pulses while stage 0 is running -> ignored; stage 1 still waits for its own edge after its start ack.
- enable deasserted during stage 0 -> the frame completes through swap, then IDLE with busy=0.
- FRAME_CNT_W=4, 16 frames from 0 -> frame_count wraps to 0.
- reset asserted in SWAP -> swap=0 and all outputs 0 the next cycle.
